pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Generic parametrised pipeline boundary register for the pipelined CPU. It is the successor to the fixed EX/MEM register.
- Adds per-stage valid tracking, a ready/valid back-pressure handshake with a 2-entry skid buffer, synchronous flush, and async reset.
- Instantiated at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) with stage-specific widths.

Parameters:
- CTRL_W, 16, control-field width; the default packs PCSrc, RegWrite, MemToReg, MemWrite, WA3[4:0], Ctrl[6:0].
- DATA_W, 64, datapath width; the default is ALUResult[31:0] concatenated with WriteData[31:0].

Ports:
- CLK  in  1  stage clock.
- RST  in  1  asynchronous, active-high reset.
- FLUSH  in  1  synchronous kill of all held and incoming beats.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept; equals !skid_valid && !FLUSH, and is 0 while RST is high.
- in_ctrl  in  CTRL_W  upstream control bits.
- in_data  in  DATA_W  upstream datapath bits.
- out_valid  out  1  main slot holds a live beat.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  main-slot control; forced to 0 whenever out_valid=0 (bubble).
- out_data  out  DATA_W  main-slot data; held value when not valid.
- occ  out  2  occupancy 0..2.

Behaviour:
- Fire conditions: in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
- States (pipe_pkg::skid_state_t): EMPTY (occ=0), FULL (main valid, occ=1), SKID (main+skid valid, occ=2).
- EMPTY:
  - in_fire -> main<=in; go to FULL.
  - else hold.
- FULL:
  - in_fire && out_fire -> main<=in; stay FULL.
  - out_fire only -> go to EMPTY.
  - in_fire only -> skid<=in; go to SKID.
  - neither -> hold.
- SKID:
  - in_ready=0, so no input is accepted.
  - out_fire -> main<=skid; go to FULL.
  - else hold.
- Latency and throughput:
  - A beat accepted at edge N appears on out_* after edge N (1-cycle latency).
  - Sustained throughput is 1 beat/cycle with out_ready=1.
- Ordering and stability:
  - Beats leave in acceptance order; none are dropped or duplicated except by FLUSH.
  - While out_valid && !out_ready, out_ctrl and out_data are stable.
- in_ready comes directly from a registered skid_valid plus FLUSH/RST gating. There is no combinational path from out_ready to in_ready.
- FLUSH=1 at an edge:
  - Main and skid valids clear; state goes to EMPTY and occ=0.
  - The concurrent input beat is not accepted (in_ready=0).
  - Data registers are not cleared.
  - FLUSH takes priority over all fire conditions.
- RST asserted (any time, including mid-transfer):
  - Immediately forces state=EMPTY, out_valid=0, out_ctrl=0, out_data=0, occ=0, in_ready=0, skid contents=0.
  - On the first edge after deassert, in_ready=1.
- Upstream is not required to hold in_* when in_ready=0. The block never samples them in that case.

Optional Feature:
- Macro: PIPE_STAGE_NEGEDGE_EN.
- Defined: all state, valid and data registers update on negedge CLK. This matches the existing half-cycle register timing; latency is measured from the falling edge.
- Undefined: all registers update on posedge CLK.
- RST remains asynchronous in both builds.

Decomposition:
- Package pipe_pkg holds:
  - skid_state_t enum {EMPTY, FULL, SKID}.
  - exmem_ctrl_t packed struct (pcsrc, regwrite, memtoreg, memwrite, wa3[4:0], ctrl[6:0]) with its width constant EXMEM_CTRL_W=16.
  - Constants OCC_EMPTY=0, OCC_FULL=1, OCC_SKID=2.
- Sub-module pipe_slot: one {valid, ctrl, data} register with load, clear and async-reset inputs. It is instantiated twice (main, skid).

Test Plan:
- Reset and pass-through:
  - Stimulus: RST high mid-stream, then release; drive in_valid=1, in_ctrl=16'h00A5, in_data=64'h1, out_ready=1.
  - Required: during reset out_valid=0, out_ctrl=0, in_ready=0. One edge after release in_ready=1; the next edge gives out_valid=1, out_ctrl=16'h00A5, out_data=1.
- Back-pressure:
  - Stimulus: stream data 1,2,3; out_ready=0 from cycle 2.
  - Required: data 1 held on out_*, data 2 in skid, occ=2, in_ready=0, data 3 not taken. Releasing out_ready delivers 1,2,3 in order, with no loss.
- Full throughput:
  - Stimulus: 100 consecutive beats (data=index), out_ready=1 always.
  - Required: 100 outputs in 100 consecutive cycles, occ never exceeds 1.
- Flush:
  - Stimulus: occ=2 with data 7,8; assert FLUSH with in_valid=1 and data 9.
  - Required: next cycle out_valid=0, out_ctrl=0, occ=0; 9 never appears.
- Random stall:
  - Stimulus: random in_valid and out_ready over 10k cycles.
  - Required: the scoreboard matches an in-order queue; out_* stable while stalled.
- Negedge build (PIPE_STAGE_NEGEDGE_EN):
  - Required: out_valid rises at the falling edge after acceptance; repeat the pass-through scenario.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the generic pipeline boundary register.
// State encoding, occupancy codes and the default EX/MEM control layout.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } skid_state_t;

    localparam int EXMEM_CTRL_W = 16;

    typedef struct packed {
        logic       pcsrc;
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic [4:0] wa3;
        logic [6:0] ctrl;
    } exmem_ctrl_t;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_FULL  = 2'd1;
    localparam logic [1:0] OCC_SKID  = 2'd2;

endpackage

// File: rtl/pipe_slot.sv
// One {valid, ctrl, data} holding register with load, clear and async reset.
// Build option PIPE_STAGE_NEGEDGE_EN moves the update to the falling clock edge.
module pipe_slot #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [DATA_W-1:0] data_d,
    output logic              vld,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic [DATA_W-1:0] data_q
);

    logic              vld_p0;
    logic [CTRL_W-1:0] ctrl_p0;
    logic [DATA_W-1:0] data_p0;

    // clear only drops the valid bit; the payload keeps its last value
`ifdef PIPE_STAGE_NEGEDGE_EN
    always_ff @(negedge clk or posedge rst) begin
`else
    always_ff @(posedge clk or posedge rst) begin
`endif
        if (rst) begin
            vld_p0 <= 1'b0;
        end else if (clr) begin
            vld_p0 <= 1'b0;
        end else if (load) begin
            vld_p0 <= 1'b1;
        end
    end

`ifdef PIPE_STAGE_NEGEDGE_EN
    always_ff @(negedge clk or posedge rst) begin
`else
    always_ff @(posedge clk or posedge rst) begin
`endif
        if (rst) begin
            ctrl_p0 <= '0;
            data_p0 <= '0;
        end else if (load && !clr) begin
            ctrl_p0 <= ctrl_d;
            data_p0 <= data_d;
        end
    end

    assign vld    = vld_p0;
    assign ctrl_q = ctrl_p0;
    assign data_q = data_p0;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline boundary register with ready/valid handshake, 2-entry skid and flush.
// Define PIPE_STAGE_NEGEDGE_EN to clock all registers on the falling edge.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FLUSH,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);

    skid_state_t       state_p0;
    logic [1:0]        occ_p0;
    logic              rdy_en_p0;

    logic              main_vld;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              skid_vld;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic              in_fire;
    logic              out_fire;
    logic              main_load;
    logic              main_clr;
    logic              main_sel_skid;
    logic              skid_load;
    logic              skid_clr;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] main_data_d;

    // rdy_en_p0 holds in_ready low until the first edge after reset release;
    // out_ready never reaches in_ready, keeping the ready chain registered
    assign in_ready = rdy_en_p0 && !skid_vld && !FLUSH && !RST;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = main_vld && out_ready;

    always_comb begin
        main_load     = 1'b0;
        main_clr      = FLUSH;
        main_sel_skid = 1'b0;
        skid_load     = 1'b0;
        skid_clr      = FLUSH;
        if (!FLUSH) begin
            case (state_p0)
                EMPTY: main_load = in_fire;
                FULL: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (out_fire) begin
                        main_clr = 1'b1;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        main_load     = 1'b1;
                        main_sel_skid = 1'b1;
                        skid_clr      = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign main_ctrl_d = main_sel_skid ? skid_ctrl : in_ctrl;
    assign main_data_d = main_sel_skid ? skid_data : in_data;

    // stage boundary: state, occupancy and ready enable
`ifdef PIPE_STAGE_NEGEDGE_EN
    always_ff @(negedge CLK or posedge RST) begin
`else
    always_ff @(posedge CLK or posedge RST) begin
`endif
        if (RST) begin
            state_p0  <= EMPTY;
            occ_p0    <= OCC_EMPTY;
            rdy_en_p0 <= 1'b0;
        end else begin
            rdy_en_p0 <= 1'b1;
            if (FLUSH) begin
                state_p0 <= EMPTY;
                occ_p0   <= OCC_EMPTY;
            end else begin
                case (state_p0)
                    EMPTY: begin
                        if (in_fire) begin
                            state_p0 <= FULL;
                            occ_p0   <= OCC_FULL;
                        end
                    end
                    FULL: begin
                        if (out_fire && !in_fire) begin
                            state_p0 <= EMPTY;
                            occ_p0   <= OCC_EMPTY;
                        end else if (in_fire && !out_fire) begin
                            state_p0 <= SKID;
                            occ_p0   <= OCC_SKID;
                        end
                    end
                    SKID: begin
                        if (out_fire) begin
                            state_p0 <= FULL;
                            occ_p0   <= OCC_FULL;
                        end
                    end
                    default: begin
                        state_p0 <= EMPTY;
                        occ_p0   <= OCC_EMPTY;
                    end
                endcase
            end
        end
    end

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk    (CLK),
        .rst    (RST),
        .load   (main_load),
        .clr    (main_clr),
        .ctrl_d (main_ctrl_d),
        .data_d (main_data_d),
        .vld    (main_vld),
        .ctrl_q (main_ctrl),
        .data_q (main_data)
    );

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk    (CLK),
        .rst    (RST),
        .load   (skid_load),
        .clr    (skid_clr),
        .ctrl_d (in_ctrl),
        .data_d (in_data),
        .vld    (skid_vld),
        .ctrl_q (skid_ctrl),
        .data_q (skid_data)
    );

    // an empty main slot presents a bubble: control bits zeroed, data held
    assign out_valid = main_vld;
    assign out_ctrl  = main_vld ? main_ctrl : '0;
    assign out_data  = main_data;
    assign occ       = occ_p0;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: accepted beats queue up, delivered beats pop.
// Follows PIPE_STAGE_NEGEDGE_EN so stimulus and sampling track the active edge.
module tb_pipe_stage_skid;

    localparam int CW = 16;
    localparam int DW = 64;

    logic          CLK = 1'b0;
    logic          RST;
    logic          FLUSH;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occ;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_out    = 0;
    int    max_occ  = 0;
    bit    hold_v   = 1'b0;
    beat_t hold_b;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .FLUSH     (FLUSH),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occ       (occ)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
`ifdef PIPE_STAGE_NEGEDGE_EN
        @(negedge CLK);
`else
        @(posedge CLK);
`endif
        #1;
    endtask

    task automatic samp();
`ifdef PIPE_STAGE_NEGEDGE_EN
        @(posedge CLK);
`else
        @(negedge CLK);
`endif
    endtask

    // input side of the scoreboard: every accepted beat is expected later, in order
`ifdef PIPE_STAGE_NEGEDGE_EN
    always @(posedge CLK) begin
`else
    always @(negedge CLK) begin
`endif
        if (!RST && in_valid && in_ready)
            exp_q.push_back(beat_t'{c: in_ctrl, d: in_data});
    end

    // output side: pop on each delivered beat, check bubbles and stall stability
`ifdef PIPE_STAGE_NEGEDGE_EN
    always @(posedge CLK) begin
`else
    always @(negedge CLK) begin
`endif
        beat_t b;
        if (RST) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("stall_ctrl", 64'(out_ctrl), 64'(hold_b.c));
                check("stall_data", out_data, hold_b.d);
            end
            if (!out_valid)
                check("bubble_ctrl", 64'(out_ctrl), 64'd0);
            if (int'(occ) > max_occ)
                max_occ = int'(occ);
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_pop: got data 0x%0h, expected no beat", out_data);
                end else begin
                    b = exp_q.pop_front();
                    check("sb_ctrl", 64'(out_ctrl), 64'(b.c));
                    check("sb_data", out_data, b.d);
                end
            end
            hold_v = out_valid && !out_ready && !FLUSH;
            hold_b = beat_t'{c: out_ctrl, d: out_data};
            if (FLUSH)
                exp_q.delete();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_out0;
        RST       = 1'b1;
        FLUSH     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;

        // reset and pass-through
        tick();
        tick();
        samp();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_occ", 64'(occ), 64'd0);
        tick();
        RST       = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 16'h00A5;
        in_data   = 64'h1;
        out_ready = 1'b1;
        tick();
        samp();
        check("rel_in_ready", 64'(in_ready), 64'd1);
        check("rel_out_valid", 64'(out_valid), 64'd0);
        tick();
        samp();
        check("pt_out_valid", 64'(out_valid), 64'd1);
        check("pt_out_ctrl", 64'(out_ctrl), 64'h00A5);
        check("pt_out_data", out_data, 64'h1);

        // asynchronous reset in the middle of a stream
        tick();
        #2;
        RST = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check("mid_rst_out_data", out_data, 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_occ", 64'(occ), 64'd0);
        exp_q.delete();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        for (int i = 0; i < 10 && !in_ready; i++)
            tick();
        check("ready_after_rst", 64'(in_ready), 64'd1);

        // back-pressure into the skid slot
        in_valid  = 1'b1;
        in_ctrl   = 16'h0101;
        in_data   = 64'd1;
        out_ready = 1'b1;
        tick();
        in_ctrl   = 16'h0202;
        in_data   = 64'd2;
        out_ready = 1'b0;
        tick();
        in_ctrl = 16'h0303;
        in_data = 64'd3;
        tick();
        samp();
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_out_data", out_data, 64'd1);
        check("bp_occ", 64'(occ), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        tick();
        samp();
        check("bp_hold_data", out_data, 64'd1);
        check("bp_hold_occ", 64'(occ), 64'd2);
        tick();
        out_ready = 1'b1;
        tick();
        samp();
        check("bp_rel_data2", out_data, 64'd2);
        check("bp_rel_occ", 64'(occ), 64'd1);
        tick();
        in_valid = 1'b0;
        samp();
        check("bp_rel_data3", out_data, 64'd3);
        check("bp_rel_ctrl3", 64'(out_ctrl), 64'h0303);
        tick();
        samp();
        check("bp_drained_valid", 64'(out_valid), 64'd0);
        check("bp_drained_occ", 64'(occ), 64'd0);

        // flush with both slots occupied and a beat offered
        tick();
        in_valid  = 1'b1;
        in_ctrl   = 16'h0707;
        in_data   = 64'd7;
        out_ready = 1'b0;
        tick();
        in_ctrl = 16'h0808;
        in_data = 64'd8;
        tick();
        FLUSH   = 1'b1;
        in_ctrl = 16'h0909;
        in_data = 64'd9;
        samp();
        check("fl_pre_occ", 64'(occ), 64'd2);
        check("fl_in_ready", 64'(in_ready), 64'd0);
        tick();
        FLUSH    = 1'b0;
        in_valid = 1'b0;
        samp();
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_out_ctrl", 64'(out_ctrl), 64'd0);
        check("fl_occ", 64'(occ), 64'd0);
        check("fl_data_kept", out_data, 64'd7);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            samp();
            check("fl_no_beat", 64'(out_valid), 64'd0);
        end

        // full throughput
        tick();
        n_out0  = n_out;
        max_occ = 0;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_ctrl  = 16'(i);
            in_data  = 64'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        samp();
        check("tp_count", 64'(n_out - n_out0), 64'd100);
        check("tp_max_occ", 64'(max_occ), 64'd1);

        // random valid/ready traffic
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_ctrl   = 16'($urandom);
            in_data   = {$urandom, $urandom};
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            tick();
        samp();
        check("rnd_queue_empty", 64'(exp_q.size()), 64'd0);
        check("rnd_out_valid", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
